// File: rtl/decodificador_display_jogador.sv
// rtl/decodificador_display_jogador.sv - debounced 7-segment to player-code decoder
// Filters the sampled pattern for N_ESTAVEL enabled samples before publishing the decoded code.
module decodificador_display_jogador #(
   parameter int N_ESTAVEL = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [6:0] display,
   output logic [1:0] jogador,
   output logic       jogador_valido,
   output logic       erro,
   output logic       novo
);

   localparam logic [7:0] N_CNT      = 8'(N_ESTAVEL);
   localparam logic [6:0] PAT_J1     = 7'b1111001;
   localparam logic [6:0] PAT_J2     = 7'b0100100;
   localparam logic [6:0] PAT_NENHUM = 7'b0111111;

   typedef enum logic {ESPERA, ESTAVEL} estado_t;

   estado_t    state_q, state_d;
   logic [6:0] candidato_q, candidato_d;
   logic [7:0] contador_q, contador_d;
   logic [1:0] jogador_q, jogador_d;
   logic       valido_q, valido_d;
   logic       erro_q, erro_d;
   logic       novo_q, novo_d;
   logic       publica;
   logic       legal;
   logic [1:0] cod;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ESPERA;
         candidato_q <= PAT_NENHUM;
         contador_q  <= 8'd0;
         jogador_q   <= 2'b00;
         valido_q    <= 1'b0;
         erro_q      <= 1'b0;
         novo_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         candidato_q <= candidato_d;
         contador_q  <= contador_d;
         jogador_q   <= jogador_d;
         valido_q    <= valido_d;
         erro_q      <= erro_d;
         novo_q      <= novo_d;
      end
   end

   always_comb begin
      candidato_d = candidato_q;
      contador_d  = contador_q;
      jogador_d   = jogador_q;
      valido_d    = valido_q;
      erro_d      = erro_q;
      novo_d      = 1'b0;
      publica     = 1'b0;
      cod         = 2'b00;
      legal       = 1'b0;

      case (display)
         PAT_J1:     begin cod = 2'b01; legal = 1'b1; end
         PAT_J2:     begin cod = 2'b10; legal = 1'b1; end
         PAT_NENHUM: begin cod = 2'b00; legal = 1'b1; end
         default:    begin cod = 2'b00; legal = 1'b0; end
      endcase

      // Any differing sample restarts the count; the new pattern is its own first sample.
      if (habilita) begin
         if (display != candidato_q) begin
            candidato_d = display;
            contador_d  = 8'd1;
            publica     = (N_CNT == 8'd1);
         end else if (state_q == ESPERA) begin
            contador_d = contador_q + 8'd1;
            publica    = (contador_d == N_CNT);
         end
      end

      state_d = (contador_d == N_CNT) ? ESTAVEL : ESPERA;

      if (publica) begin
         jogador_d = legal ? cod : 2'b00;
         erro_d    = !legal;
         valido_d  = legal && (cod != 2'b00);
         novo_d    = ({jogador_d, erro_d} != {jogador_q, erro_q});
      end
   end

   assign jogador        = jogador_q;
   assign jogador_valido = valido_q;
   assign erro           = erro_q;
   assign novo           = novo_q;

endmodule

// File: tb/tb_decodificador_display_jogador.sv
// tb/tb_decodificador_display_jogador.sv - scoreboard bench for decodificador_display_jogador
module tb_decodificador_display_jogador;

   logic       clock = 1'b0;
   logic       reset;
   logic       habilita;
   logic [6:0] display;
   logic [1:0] jogador,  jogador_n1;
   logic       valido,   valido_n1;
   logic       erro,     erro_n1;
   logic       novo,     novo_n1;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected {jogador, jogador_valido, erro, novo} after each driven edge.
   logic [4:0] sb[$];

   always #5 clock = ~clock;

   decodificador_display_jogador #(.N_ESTAVEL(4)) dut (
      .clock(clock), .reset(reset), .habilita(habilita), .display(display),
      .jogador(jogador), .jogador_valido(valido), .erro(erro), .novo(novo)
   );

   decodificador_display_jogador #(.N_ESTAVEL(1)) dut_n1 (
      .clock(clock), .reset(reset), .habilita(habilita), .display(display),
      .jogador(jogador_n1), .jogador_valido(valido_n1), .erro(erro_n1), .novo(novo_n1)
   );

   task automatic drive(input logic [6:0] d, input logic h, input logic r, input logic [4:0] e);
      display  = d;
      habilita = h;
      reset    = r;
      sb.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] e;
      drive(7'b0000000, 1'b1, 1'b1, 5'b00_0_0_0);
      drive(7'b1111001, 1'b1, 1'b1, 5'b00_0_0_0);
      for (int i = 0; i < 2; i++) begin
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL reset: got %b required %b", {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_publish_01();
      logic [4:0] e;
      logic [4:0] exp_t[6] = '{5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0,
                               5'b01_1_0_1, 5'b01_1_0_0, 5'b01_1_0_0};
      for (int i = 0; i < 6; i++) begin
         drive(7'b1111001, 1'b1, 1'b0, exp_t[i]);
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL publish_01 edge %0d: got %b required %b", i + 1, {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_glitch();
      logic [4:0] e;
      for (int i = 0; i < 7; i++) begin
         drive((i < 2) ? 7'b0100100 : 7'b1111001, 1'b1, 1'b0, 5'b01_1_0_0);
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL glitch edge %0d: got %b required %b", i + 1, {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_dash_and_error();
      logic [4:0] e;
      logic [6:0] pat_t[9] = '{7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111,
                               7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
      logic [4:0] exp_t[9] = '{5'b01_1_0_0, 5'b01_1_0_0, 5'b01_1_0_0, 5'b00_0_0_1,
                               5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_1_1, 5'b00_0_1_0};
      for (int i = 0; i < 9; i++) begin
         drive(pat_t[i], 1'b1, 1'b0, exp_t[i]);
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL dash_error edge %0d: got %b required %b", i + 1, {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_habilita();
      logic [4:0] e;
      logic       hab_t[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [4:0] exp_t[8] = '{5'b00_0_1_0, 5'b00_0_1_0, 5'b00_0_1_0, 5'b00_0_1_0,
                               5'b00_0_1_0, 5'b00_0_1_0, 5'b10_1_0_1, 5'b10_1_0_0};
      for (int i = 0; i < 8; i++) begin
         drive(7'b0100100, hab_t[i], 1'b0, exp_t[i]);
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL habilita edge %0d: got %b required %b", i + 1, {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_reset_midcount();
      logic [4:0] e;
      logic       rst_t[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [4:0] exp_t[9] = '{5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0,
                               5'b00_0_0_0, 5'b00_0_0_0, 5'b00_0_0_0, 5'b10_1_0_1};
      for (int i = 0; i < 9; i++) begin
         drive(7'b0100100, 1'b1, rst_t[i], exp_t[i]);
         e = sb.pop_front();
         n_checks++;
         if ({jogador, valido, erro, novo} !== e) begin
            n_fail++;
            $display("FAIL reset_midcount edge %0d: got %b required %b", i + 1, {jogador, valido, erro, novo}, e);
         end
      end
   endtask

   task automatic test_back_to_back_n1();
      logic [4:0] e;
      logic [6:0] pat_t[6] = '{7'b0111111, 7'b1111001, 7'b0100100, 7'b0100100, 7'b0111111, 7'b1111001};
      logic       rst_t[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [4:0] exp_t[6] = '{5'b00_0_0_0, 5'b01_1_0_1, 5'b10_1_0_1,
                               5'b10_1_0_0, 5'b00_0_0_1, 5'b01_1_0_1};
      for (int i = 0; i < 6; i++) begin
         drive(pat_t[i], 1'b1, rst_t[i], exp_t[i]);
         e = sb.pop_front();
         n_checks++;
         if ({jogador_n1, valido_n1, erro_n1, novo_n1} !== e) begin
            n_fail++;
            $display("FAIL n1 edge %0d: got %b required %b", i + 1, {jogador_n1, valido_n1, erro_n1, novo_n1}, e);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      habilita = 1'b0;
      display  = 7'b0111111;
      @(negedge clock);
      test_reset();
      test_publish_01();
      test_glitch();
      test_dash_and_error();
      test_habilita();
      test_reset_midcount();
      test_back_to_back_n1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
